// File: rtl/arbiter_client.sv
// ---------------------------------------------------------------------------
// arbiter_client
//
// Requester-side agent for a strict-priority shared-resource arbiter.
// It accepts one burst-write command, raises req and waits for gnt. It then
// streams cmd_len+1 beats onto the shared bus with an incrementing
// (wrapping) address, and pulses end_access with the last beat so the
// arbiter can re-arbitrate. If gnt is lost mid-burst, it pulses abort and
// returns to idle without end_access.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (cmd_ready = idle)
//   cmd_addr, cmd_len     burst start address, beats minus one
//   src_valid/src_ready   write-data handshake (src_ready = transferring)
//   src_data              write data beat
//   req, gnt, end_access  arbiter lane signals
//   bus_en/addr/wdata     registered bus write strobe, address, data
//   busy                  registered, high whenever not idle
//   abort                 one-cycle pulse when gnt drops mid-burst
// ---------------------------------------------------------------------------
module arbiter_client #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic [DATA_W-1:0] src_data,
    output logic              req,
    input  logic              gnt,
    output logic              end_access,
    output logic              bus_en,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              busy,
    output logic              abort
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [LEN_W-1:0]  len_reg, len_next;
    logic [LEN_W-1:0]  count_reg, count_next;

    logic              req_reg, req_next;
    logic              end_access_reg, end_access_next;
    logic              bus_en_reg, bus_en_next;
    logic [ADDR_W-1:0] bus_addr_reg, bus_addr_next;
    logic [DATA_W-1:0] bus_wdata_reg, bus_wdata_next;
    logic              busy_reg, busy_next;
    logic              abort_reg, abort_next;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            len_reg        <= '0;
            count_reg      <= '0;
            req_reg        <= 1'b0;
            end_access_reg <= 1'b0;
            bus_en_reg     <= 1'b0;
            bus_addr_reg   <= '0;
            bus_wdata_reg  <= '0;
            busy_reg       <= 1'b0;
            abort_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            len_reg        <= len_next;
            count_reg      <= count_next;
            req_reg        <= req_next;
            end_access_reg <= end_access_next;
            bus_en_reg     <= bus_en_next;
            bus_addr_reg   <= bus_addr_next;
            bus_wdata_reg  <= bus_wdata_next;
            busy_reg       <= busy_next;
            abort_reg      <= abort_next;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        len_next        = len_reg;
        count_next      = count_reg;
        req_next        = req_reg;
        end_access_next = 1'b0;
        bus_en_next     = 1'b0;
        bus_addr_next   = bus_addr_reg;
        bus_wdata_next  = bus_wdata_reg;
        abort_next      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    addr_next  = cmd_addr;
                    len_next   = cmd_len;
                    count_next = '0;
                    req_next   = 1'b1;
                    state_next = REQ;
                end
            end

            REQ: begin
                if (gnt) begin
                    state_next = XFER;
                end
            end

            XFER: begin
                // A beat taken this cycle goes out next cycle even if the
                // grant is lost at the same time.
                if (src_valid) begin
                    bus_en_next    = 1'b1;
                    bus_addr_next  = addr_reg;
                    bus_wdata_next = src_data;
                    addr_next      = addr_reg + ADDR_W'(1);
                    count_next     = count_reg + LEN_W'(1);
                end
                if (!gnt) begin
                    abort_next = 1'b1;
                    req_next   = 1'b0;
                    state_next = IDLE;
                end else if (src_valid && (count_reg == len_reg)) begin
                    // end_access is registered alongside the last bus_en
                    req_next        = 1'b0;
                    end_access_next = 1'b1;
                    state_next      = DONE;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    assign cmd_ready  = (state_reg == IDLE);
    assign src_ready  = (state_reg == XFER);
    assign req        = req_reg;
    assign end_access = end_access_reg;
    assign bus_en     = bus_en_reg;
    assign bus_addr   = bus_addr_reg;
    assign bus_wdata  = bus_wdata_reg;
    assign busy       = busy_reg;
    assign abort      = abort_reg;

endmodule
